keypad_scan: RTL

//  4x4 matrix keypad scanner; the source side of the 16-bit one-hot key bus consumed by the lock/display logic.

---
 rtl/keypad_scan_pkg.sv | 33 +++
 rtl/keypad_scan_sync2.sv | 28 ++
 rtl/keypad_scan.sv | 126 ++++++++++++
 3 files changed

// File: rtl/keypad_scan_pkg.sv
// Shared keypad definitions: key codes as seen by the digit/password decoder,
// matrix geometry and a small popcount helper.
package keypad_scan_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [15:0] KEY_NONE = 16'h0000;

  // Bit index into the one-hot bus is {row[1:0], col[1:0]}
  localparam logic [3:0] KEY_1     = 4'd0;
  localparam logic [3:0] KEY_2     = 4'd1;
  localparam logic [3:0] KEY_3     = 4'd2;
  localparam logic [3:0] KEY_4     = 4'd4;
  localparam logic [3:0] KEY_5     = 4'd5;
  localparam logic [3:0] KEY_6     = 4'd6;
  localparam logic [3:0] KEY_7     = 4'd8;
  localparam logic [3:0] KEY_8     = 4'd9;
  localparam logic [3:0] KEY_9     = 4'd10;
  localparam logic [3:0] KEY_CLEAR = 4'd12;
  localparam logic [3:0] KEY_0     = 4'd13;
  localparam logic [3:0] KEY_ENTER = 4'd14;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer for the asynchronous keypad row lines; idles high
// because the rows are pulled up.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] q_r;

  // Metastability filter stages
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= {WIDTH{1'b1}};
      q_r    <= {WIDTH{1'b1}};
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row sampling into a full-matrix
// snapshot, whole-snapshot debounce and one-hot key commit.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV       = 50_000,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] onehot,
  output logic        key_valid,
  output logic        key_pulse
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);

  logic [3:0]        row_sync_s;
  logic [SLOT_W-1:0] slot_cnt_r;
  logic [1:0]        col_r;
  logic [1:0]        col_inc_s;
  logic [3:0]        col_out_r;
  logic [15:0]       snapshot_r;
  logic [15:0]       prev_r;
  logic [CNT_W-1:0]  stable_cnt_r;
  logic [15:0]       onehot_r;
  logic              key_valid_r;
  logic              key_pulse_r;

  logic              slot_end_s;
  logic              scan_end_s;
  logic [15:0]       snap_next_s;
  logic [15:0]       prev_next_s;
  logic [CNT_W-1:0]  stable_next_s;
  logic              commit_s;
  logic [15:0]       commit_val_s;

  sync2 #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_in),
    .q   (row_sync_s)
  );

  assign slot_end_s = (slot_cnt_r == SLOT_LAST);
  assign scan_end_s = slot_end_s && (col_r == 2'd3);
  assign col_inc_s  = col_r + 2'd1;

  // Merge the current column's rows into the snapshot at the end of its slot
  always_comb begin
    snap_next_s = snapshot_r;
    if (slot_end_s) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        snap_next_s[{r[1:0], col_r}] = ~row_sync_s[r[1:0]];
      end
    end else begin
      snap_next_s = snapshot_r;
    end
  end

  // Debounce on whole scans; commit only on the transition into saturation
  always_comb begin
    prev_next_s   = prev_r;
    stable_next_s = stable_cnt_r;
    commit_s      = 1'b0;
    if (scan_end_s) begin
      if (snap_next_s != prev_r) begin
        prev_next_s   = snap_next_s;
        stable_next_s = CNT_W'(1);
      end else if (stable_cnt_r < CNT_MAX) begin
        stable_next_s = stable_cnt_r + CNT_W'(1);
        commit_s      = ((stable_cnt_r + CNT_W'(1)) == CNT_MAX);
      end else begin
        stable_next_s = stable_cnt_r;
      end
    end else begin
      commit_s = 1'b0;
    end
  end

  // Multi-press or ghosting collapses to "no key"
  assign commit_val_s = (popcount16(snap_next_s) == 5'd1) ? snap_next_s : KEY_NONE;

  // Scan counters, snapshot, debounce state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_r   <= '0;
      col_r        <= 2'd0;
      col_out_r    <= 4'b1110;
      snapshot_r   <= KEY_NONE;
      prev_r       <= KEY_NONE;
      stable_cnt_r <= '0;
      onehot_r     <= KEY_NONE;
      key_valid_r  <= 1'b0;
      key_pulse_r  <= 1'b0;
    end else begin
      snapshot_r   <= snap_next_s;
      prev_r       <= prev_next_s;
      stable_cnt_r <= stable_next_s;
      key_pulse_r  <= 1'b0;
      if (slot_end_s) begin
        slot_cnt_r <= '0;
        col_r      <= col_inc_s;
        col_out_r  <= ~(4'b0001 << col_inc_s);
      end else begin
        slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
      end
      if (commit_s) begin
        onehot_r    <= commit_val_s;
        key_valid_r <= (commit_val_s != KEY_NONE);
        key_pulse_r <= (commit_val_s != KEY_NONE) && (commit_val_s != onehot_r);
      end
    end
  end

  assign col_out   = col_out_r;
  assign onehot    = onehot_r;
  assign key_valid = key_valid_r;
  assign key_pulse = key_pulse_r;

endmodule
